// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FP add/sub normalisation datapath.
// Double-precision defaults, the result flag bundle and a clog2 helper.
package fpu_norm_pkg;

    localparam int MANT_W_DP = 107;
    localparam int EXP_W_DP  = 11;
    localparam int SH_W_DP   = 7;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
        logic right;
    } norm_flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter: count = zeros above the highest set bit,
// count = W and all_zero = 1 when no bit is set.
module lzc_tree
    import fpu_norm_pkg::*;
#(
    parameter int W     = 106,
    parameter int CNT_W = clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scanning upwards lets the highest set bit win; synthesis flattens this into a priority tree.
    always_comb begin
        count    = CNT_W'(W);
        all_zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count    = CNT_W'(W - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage elastic normalisation stage between mantissa add/sub and the rounder.
// S1 captures the operands plus carry and leading-zero count; S2 shifts, adjusts the exponent and flags.
module fp_norm_pipe
    import fpu_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DP,
    parameter int EXP_W  = EXP_W_DP,
    parameter int SH_W   = SH_W_DP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_add,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SH_W-1:0]   out_shift,
    output logic              out_right,
    output logic              out_zero,
    output logic              out_underflow,
    output logic              out_overflow
);

    // Handshake: a beat moves on valid & ready. A stage advances when it is empty
    // or its successor advances, so the pipe holds two beats and runs bubble-free.
    logic adv1, adv2;
    logic s1_valid, s2_valid;

    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_add, s1_carry, s1_low_zero;
    logic [SH_W-1:0]   s1_lzc;

    logic [SH_W-1:0]   lzc;
    logic              low_zero;

    norm_flags_t       s2_flags;

    logic [MANT_W-1:0] n_mant, sub_mant;
    logic [EXP_W-1:0]  n_exp, exp_inc, lzc_ext;
    logic [SH_W-1:0]   n_shift, uf_shift;
    norm_flags_t       n_flags;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    lzc_tree #(.W(MANT_W - 1), .CNT_W(SH_W)) u_lzc (
        .din      (in_mant[MANT_W-2:0]),
        .count    (lzc),
        .all_zero (low_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_mant     <= '0;
            s1_exp      <= '0;
            s1_add      <= 1'b0;
            s1_carry    <= 1'b0;
            s1_low_zero <= 1'b0;
            s1_lzc      <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant     <= in_mant;
                s1_exp      <= in_exp;
                s1_add      <= in_add;
                s1_carry    <= in_mant[MANT_W-1];
                s1_low_zero <= low_zero;
                s1_lzc      <= lzc;
            end
        end
    end

    always_comb begin
        n_mant   = s1_mant;
        n_exp    = s1_exp;
        n_shift  = '0;
        n_flags  = '0;
        exp_inc  = s1_exp + 1'b1;
        lzc_ext  = EXP_W'(s1_lzc);
        // The carry bit carries no meaning on the subtract path.
        sub_mant = {1'b0, s1_mant[MANT_W-2:0]};
        uf_shift = (s1_exp == '0) ? '0 : SH_W'(s1_exp - 1'b1);
        if (s1_add) begin
            if (s1_carry) begin
                n_mant           = s1_mant >> 1;
                n_exp            = exp_inc;
                n_shift          = SH_W'(1);
                n_flags.right    = 1'b1;
                n_flags.overflow = &exp_inc;
            end
        end else if (s1_low_zero) begin
            n_mant       = '0;
            n_exp        = '0;
            n_shift      = SH_W'(MANT_W - 1);
            n_flags.zero = 1'b1;
        end else if (lzc_ext < s1_exp) begin
            n_mant  = sub_mant << s1_lzc;
            n_exp   = s1_exp - lzc_ext;
            n_shift = s1_lzc;
        end else begin
            // Shift only as far as the exponent allows, leaving a subnormal at exponent 0.
            n_mant            = sub_mant << uf_shift;
            n_exp             = '0;
            n_shift           = uf_shift;
            n_flags.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_shift <= '0;
            s2_flags  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_mant  <= n_mant;
                out_exp   <= n_exp;
                out_shift <= n_shift;
                s2_flags  <= n_flags;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_right     = s2_flags.right;
    assign out_zero      = s2_flags.zero;
    assign out_underflow = s2_flags.underflow;
    assign out_overflow  = s2_flags.overflow;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe: directed cases, backpressure, mid-flight reset
// and randomized traffic scored against a behavioural normalisation model.
module tb_fp_norm_pipe;

    localparam int MANT_W = 107;
    localparam int EXP_W  = 11;
    localparam int SH_W   = 7;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic [SH_W-1:0]   shift;
        logic              right;
        logic              zero;
        logic              uf;
        logic              of;
    } res_t;

    localparam int RES_W = $bits(res_t);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant = '0;
    logic [EXP_W-1:0]  in_exp = '0;
    logic              in_add = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic [SH_W-1:0]   out_shift;
    logic              out_right, out_zero, out_underflow, out_overflow;

    fp_norm_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W), .SH_W(SH_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .in_add        (in_add),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_shift     (out_shift),
        .out_right     (out_right),
        .out_zero      (out_zero),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [RES_W-1:0] exp_q[$];

    logic              pend_v = 1'b0;
    logic [MANT_W-1:0] pend_m = '0;
    logic [EXP_W-1:0]  pend_e = '0;
    logic              pend_a = 1'b0;
    logic              ordy   = 1'b0;
    int                accepted = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    endtask

    // Reference: normalisation rules written directly over integers.
    function automatic res_t model(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e, input logic add);
        res_t r;
        logic [MANT_W-1:0] low;
        int ei, msb, lz, sh;
        r  = '0;
        ei = int'(e);
        if (add) begin
            if (m[MANT_W-1]) begin
                r.mant  = m >> 1;
                r.exp   = EXP_W'((ei + 1) % (1 << EXP_W));
                r.shift = 1;
                r.right = 1'b1;
                r.of    = ((ei + 1) == (1 << EXP_W) - 1);
            end else begin
                r.mant = m;
                r.exp  = e;
            end
        end else begin
            low = m;
            low[MANT_W-1] = 1'b0;
            if (low == 0) begin
                r.zero  = 1'b1;
                r.shift = SH_W'(MANT_W - 1);
            end else begin
                msb = MANT_W - 2;
                while (!low[msb]) msb--;
                lz = (MANT_W - 2) - msb;
                if (lz < ei) begin
                    r.mant  = low << lz;
                    r.exp   = EXP_W'(ei - lz);
                    r.shift = SH_W'(lz);
                end else begin
                    sh      = (ei == 0) ? 0 : ei - 1;
                    r.mant  = low << sh;
                    r.shift = SH_W'(sh);
                    r.uf    = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // driver + scoreboard: one clock cycle, inputs driven 1 time unit after the edge
    task automatic run_cycle();
        res_t r;
        in_valid  = pend_v;
        out_ready = ordy;
        if (pend_v) begin
            in_mant = pend_m;
            in_exp  = pend_e;
            in_add  = pend_a;
        end else begin
            in_mant = {$urandom, $urandom, $urandom, $urandom};
            in_exp  = EXP_W'($urandom);
            in_add  = 1'($urandom);
        end
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {127'd0, out_valid}, 128'd0);
            end else begin
                r = res_t'(exp_q.pop_front());
                check("mant",  out_mant, r.mant);
                check("exp",   out_exp, r.exp);
                check("shift", out_shift, r.shift);
                check("flags", {out_right, out_zero, out_underflow, out_overflow},
                      {r.right, r.zero, r.uf, r.of});
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(RES_W'(model(in_mant, in_exp, in_add)));
            pend_v = 1'b0;
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e, input logic a);
        int guard;
        pend_v = 1'b1; pend_m = m; pend_e = e; pend_a = a;
        guard = 0;
        while (pend_v && guard < 50) begin
            run_cycle();
            guard++;
        end
        if (pend_v) check("send_timeout", {127'd0, pend_v}, 128'd0);
    endtask

    task automatic drain();
        int guard;
        ordy  = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || pend_v) && guard < 50) begin
            run_cycle();
            guard++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    function automatic logic [MANT_W-1:0] one_hot(input int b);
        logic [MANT_W-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [MANT_W-1:0] rand_mant();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r = r >> $urandom_range(0, 127);
        return r[MANT_W-1:0];
    endfunction

    function automatic logic [EXP_W-1:0] rand_exp();
        case ($urandom_range(0, 3))
            0:       return EXP_W'($urandom_range(0, 20));
            1:       return 11'h7FE;
            2:       return EXP_W'($urandom);
            default: return EXP_W'($urandom_range(90, 120));
        endcase
    endfunction

    initial begin
        logic [MANT_W-1:0] snap_mant;
        logic [EXP_W-1:0]  snap_exp;
        logic              have_snap;
        int                idx, guard;
        logic [MANT_W-1:0] bp_m[3];

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready",  {127'd0, in_ready}, 128'd1);
        check("rst_mant",      out_mant, 128'd0);
        check("rst_exp",       out_exp, 128'd0);
        check("rst_shift",     out_shift, 128'd0);
        check("rst_flags",     {out_right, out_zero, out_underflow, out_overflow}, 128'd0);
        @(posedge clk);
        #1;

        // directed cases
        ordy = 1'b1;
        send(one_hot(106) | 107'h1234_5678_9ABC_DEF1, 11'h400, 1'b1);
        send(one_hot(100), 11'h400, 1'b0);
        send('0, 11'h400, 1'b0);
        send(one_hot(50), 11'd10, 1'b0);
        send(one_hot(106) | one_hot(3), 11'h7FE, 1'b1);
        send(one_hot(105) | one_hot(7), 11'h123, 1'b1);
        send(one_hot(106) | one_hot(100), 11'h400, 1'b0);
        send(one_hot(106), 11'h055, 1'b0);
        send(one_hot(0), 11'd0, 1'b0);
        send(one_hot(20), 11'd85, 1'b0);
        drain();

        // backpressure: three beats against a stalled output for five cycles
        bp_m[0] = rand_mant() | one_hot(90);
        bp_m[1] = rand_mant() | one_hot(80);
        bp_m[2] = rand_mant() | one_hot(70);
        accepted  = 0;
        idx       = 0;
        have_snap = 1'b0;
        snap_mant = '0;
        snap_exp  = '0;
        ordy      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!pend_v && idx < 3) begin
                pend_v = 1'b1; pend_m = bp_m[idx]; pend_e = 11'h200; pend_a = 1'b0;
                idx++;
            end
            run_cycle();
            if (out_valid) begin
                if (!have_snap) begin
                    snap_mant = out_mant;
                    snap_exp  = out_exp;
                    have_snap = 1'b1;
                end else begin
                    check("hold_mant", out_mant, snap_mant);
                    check("hold_exp",  out_exp, snap_exp);
                end
            end
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        check("bp_out_valid", {127'd0, out_valid}, 128'd1);
        ordy  = 1'b1;
        guard = 0;
        while (idx < 3 && guard < 20) begin
            if (!pend_v) begin
                pend_v = 1'b1; pend_m = bp_m[idx]; pend_e = 11'h200; pend_a = 1'b0;
                idx++;
            end
            run_cycle();
            guard++;
        end
        drain();

        // reset with two beats in flight
        ordy = 1'b0;
        send(one_hot(60), 11'h300, 1'b0);
        send(one_hot(61), 11'h301, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        rst = 1'b0;
        exp_q.delete();
        ordy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            check("post_rst_quiet", {127'd0, out_valid}, 128'd0);
        end

        // randomized traffic with random backpressure
        accepted = 0;
        guard    = 0;
        while (accepted < 300 && guard < 5000) begin
            if (!pend_v && $urandom_range(0, 3) != 0) begin
                pend_v = 1'b1;
                pend_m = rand_mant();
                pend_e = rand_exp();
                pend_a = 1'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            run_cycle();
            guard++;
        end
        check("rand_accepted", accepted, 300);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
